// File: rtl/lsq_mem_ctrl.sv
// rtl/lsq_mem_ctrl.sv - LSQ head memory sequencer: one access in flight, strict head order.
module lsq_mem_ctrl #(
    parameter int TAG_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  head_valid,
    input  logic                  head_is_load,
    input  logic [TAG_WIDTH-1:0]  head_tag,
    input  logic [DATA_WIDTH-1:0] head_addr,
    input  logic [DATA_WIDTH-1:0] head_data,
    input  logic                  store_commit,
    input  logic                  flush,
    output logic                  deq,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wb_valid,
    output logic [TAG_WIDTH-1:0]  wb_tag,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int CNT_WIDTH = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t                 state;
    logic                   lat_is_load;
    logic [TAG_WIDTH-1:0]   lat_tag;
    logic [CNT_WIDTH-1:0]   wait_cnt;
    logic                   drop;

    logic                   accept;
    logic                   squash;
    logic                   timed_out;

    assign accept    = head_valid && !flush && (head_is_load || store_commit);
    assign squash    = drop || flush;
    assign timed_out = (state == WAIT) && !mem_rvalid && (wait_cnt == LAST_WAIT);

    // Handshake-qualified outputs must react within the cycle, so they are
    // decoded from the registered state rather than registered themselves.
    assign mem_req  = (state == REQ) && !(flush && lat_is_load);
    assign mem_we   = (state == REQ) && !lat_is_load;
    assign wb_valid = (state == WB) && !flush;
    assign deq      = (mem_req && mem_ready && !lat_is_load) || wb_valid ||
                      (timed_out && !squash);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lat_is_load <= 1'b0;
            lat_tag     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wb_tag      <= '0;
            wb_data     <= '0;
            wait_cnt    <= '0;
            drop        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (accept) begin
                        lat_is_load <= head_is_load;
                        lat_tag     <= head_tag;
                        mem_addr    <= head_addr;
                        mem_wdata   <= head_data;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    // A committed store is architecturally retired, so flush cannot stop it.
                    if (flush && lat_is_load) begin
                        state <= IDLE;
                    end else if (mem_ready) begin
                        if (lat_is_load) begin
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        drop <= 1'b0;
                        if (squash) begin
                            state <= IDLE;
                        end else begin
                            wb_tag  <= lat_tag;
                            wb_data <= mem_rdata;
                            state   <= WB;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        timeout_err <= 1'b1;
                        drop        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (flush) begin
                            drop <= 1'b1;
                        end
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsq_mem_ctrl.sv
// tb/tb_lsq_mem_ctrl.sv - directed bench for lsq_mem_ctrl with a per-cycle reference model.
module tb_lsq_mem_ctrl;
    localparam int MAXW = 8;

    logic        clk, rst;
    logic        head_valid, head_is_load, store_commit, flush;
    logic [3:0]  head_tag;
    logic [31:0] head_addr, head_data;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        deq, mem_req, mem_we, wb_valid, busy, timeout_err;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  wb_tag;

    int checks = 0;
    int failures = 0;
    int deq_seen = 0;
    int d0;

    lsq_mem_ctrl #(.TAG_WIDTH(4), .DATA_WIDTH(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .head_valid(head_valid), .head_is_load(head_is_load), .head_tag(head_tag),
        .head_addr(head_addr), .head_data(head_data),
        .store_commit(store_commit), .flush(flush),
        .deq(deq), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        head_valid = 1'b0; head_is_load = 1'b0; head_tag = 4'h0;
        head_addr = 32'h0; head_data = 32'h0; store_commit = 1'b0; flush = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    // Reference model: the open transaction, whether memory took it, how many
    // response cycles have elapsed, and whether load data is waiting to retire.
    logic        m_open, m_load, m_issued, m_have, m_squash, m_terr;
    logic [3:0]  m_tag, m_wb_tag;
    logic [31:0] m_addr, m_wdata, m_wb_data;
    int          m_waited;
    logic        e_req, e_we, e_wbv, e_deq, expired;

    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            chk1("rst_deq", deq, 1'b0);
            chk1("rst_mem_req", mem_req, 1'b0);
            chk1("rst_mem_we", mem_we, 1'b0);
            chk1("rst_wb_valid", wb_valid, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_timeout_err", timeout_err, 1'b0);
            chk32("rst_mem_addr", mem_addr, 32'h0);
            chk32("rst_mem_wdata", mem_wdata, 32'h0);
            chk32("rst_wb_tag", 32'(wb_tag), 32'h0);
            chk32("rst_wb_data", wb_data, 32'h0);
            m_open = 0; m_load = 0; m_issued = 0; m_have = 0; m_squash = 0; m_terr = 0;
            m_tag = 0; m_wb_tag = 0; m_addr = 0; m_wdata = 0; m_wb_data = 0; m_waited = 0;
        end else begin
            e_req   = m_open && !m_issued && !(flush && m_load);
            e_we    = m_open && !m_issued && !m_load;
            e_wbv   = m_have && !flush;
            expired = m_open && m_issued && !m_have && !mem_rvalid && (m_waited + 1 == MAXW);
            e_deq   = (e_req && mem_ready && !m_load) || e_wbv || (expired && !m_squash && !flush);
            chk1("m_busy", busy, m_open);
            chk1("m_mem_req", mem_req, e_req);
            chk1("m_mem_we", mem_we, e_we);
            chk1("m_wb_valid", wb_valid, e_wbv);
            chk1("m_deq", deq, e_deq);
            chk1("m_timeout_err", timeout_err, m_terr);
            chk32("m_mem_addr", mem_addr, m_addr);
            chk32("m_mem_wdata", mem_wdata, m_wdata);
            chk32("m_wb_tag", 32'(wb_tag), 32'(m_wb_tag));
            chk32("m_wb_data", wb_data, m_wb_data);
            if (!m_open) begin
                if (head_valid && !flush && (head_is_load || store_commit)) begin
                    m_open = 1; m_load = head_is_load; m_tag = head_tag;
                    m_addr = head_addr; m_wdata = head_data;
                    m_issued = 0; m_have = 0; m_squash = 0;
                end
            end else if (!m_issued) begin
                if (flush && m_load) m_open = 0;
                else if (mem_ready) begin
                    if (!m_load) m_open = 0;
                    else begin m_issued = 1; m_waited = 0; end
                end
            end else if (m_have) begin
                m_open = 0; m_have = 0;
            end else if (mem_rvalid) begin
                if (m_squash || flush) m_open = 0;
                else begin m_have = 1; m_wb_tag = m_tag; m_wb_data = mem_rdata; end
            end else if (expired) begin
                m_terr = 1; m_open = 0;
            end else begin
                m_waited++;
                m_squash = m_squash || flush;
            end
        end
        if (deq === 1'b1) deq_seen++;
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #3;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_timeout_err", timeout_err, 1'b0);
        chk32("reset_mem_addr", mem_addr, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // Load tag 3 @0x100, ready next cycle, data two cycles later
        head_valid = 1; head_is_load = 1; head_tag = 4'd3; head_addr = 32'h100;
        @(negedge clk); mem_ready = 1;
        #3 chk1("a_req", mem_req, 1'b1); chk32("a_addr", mem_addr, 32'h100); chk1("a_we", mem_we, 1'b0);
        @(negedge clk); mem_ready = 0;
        #3 chk1("a_wait_deq", deq, 1'b0);
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk); mem_rvalid = 0;
        #3 chk1("a_wb_valid", wb_valid, 1'b1); chk32("a_wb_tag", 32'(wb_tag), 32'd3);
        chk32("a_wb_data", wb_data, 32'hDEADBEEF); chk1("a_deq", deq, 1'b1);
        @(negedge clk); head_valid = 0;
        #3 chk1("a_idle_busy", busy, 1'b0); chk1("a_idle_wbv", wb_valid, 1'b0);
        @(negedge clk);

        // Store 0x5 @0x40 waits for commit, then memory stalls three cycles
        head_valid = 1; head_is_load = 0; head_addr = 32'h40; head_data = 32'h5;
        for (int i = 0; i < 5; i++) begin
            #3 chk1("b_nocommit_req", mem_req, 1'b0);
            @(negedge clk);
        end
        store_commit = 1;
        @(negedge clk); store_commit = 0;
        for (int i = 0; i < 3; i++) begin
            #3 chk1("b_req", mem_req, 1'b1); chk1("b_we", mem_we, 1'b1);
            chk32("b_addr", mem_addr, 32'h40); chk32("b_wdata", mem_wdata, 32'h5);
            chk1("b_stall_deq", deq, 1'b0);
            @(negedge clk);
        end
        mem_ready = 1;
        #3 chk1("b_hs_deq", deq, 1'b1); chk1("b_hs_req", mem_req, 1'b1);
        @(negedge clk); mem_ready = 0; head_valid = 0;
        #3 chk1("b_after_busy", busy, 1'b0); chk1("b_after_deq", deq, 1'b0);
        @(negedge clk);

        // Flush while waiting for load data
        head_valid = 1; head_is_load = 1; head_tag = 4'd5; head_addr = 32'h200;
        @(negedge clk); mem_ready = 1;
        @(negedge clk); mem_ready = 0; flush = 1; head_valid = 0;
        @(negedge clk); flush = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
        #3 chk1("c_deq", deq, 1'b0); chk1("c_wbv", wb_valid, 1'b0); chk1("c_busy", busy, 1'b1);
        @(negedge clk); mem_rvalid = 0;
        #3 chk1("c_idle_busy", busy, 1'b0); chk1("c_idle_wbv", wb_valid, 1'b0);
        @(negedge clk);

        // Load with no response: timeout after MAXW wait cycles
        head_valid = 1; head_is_load = 1; head_tag = 4'd7; head_addr = 32'h300;
        @(negedge clk); mem_ready = 1;
        @(negedge clk); mem_ready = 0;
        for (int k = 1; k <= MAXW; k++) begin
            #3 chk1("d_deq", deq, k == MAXW); chk1("d_terr", timeout_err, 1'b0);
            chk1("d_wbv", wb_valid, 1'b0);
            @(negedge clk);
        end
        head_valid = 0;
        #3 chk1("d_terr_set", timeout_err, 1'b1); chk1("d_busy", busy, 1'b0);
        @(negedge clk);

        // Load answered immediately, then a committed store
        d0 = deq_seen;
        head_valid = 1; head_is_load = 1; head_tag = 4'd2; head_addr = 32'h10;
        @(negedge clk); mem_ready = 1;
        @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
        #3 chk1("e_wait_req", mem_req, 1'b0);
        @(negedge clk); mem_rvalid = 0;
        #3 chk1("e_wbv", wb_valid, 1'b1); chk1("e_wb_deq", deq, 1'b1); chk1("e_wb_req", mem_req, 1'b0);
        chk32("e_wb_data", wb_data, 32'hCAFE); chk32("e_wb_tag", 32'(wb_tag), 32'd2);
        @(negedge clk); head_is_load = 0; head_addr = 32'h20; head_data = 32'h77; store_commit = 1;
        #3 chk1("e_idle_req", mem_req, 1'b0);
        @(negedge clk); store_commit = 0; mem_ready = 1;
        #3 chk1("e_st_req", mem_req, 1'b1); chk1("e_st_we", mem_we, 1'b1); chk1("e_st_deq", deq, 1'b1);
        @(negedge clk); mem_ready = 0; head_valid = 0;
        #3 chk1("e_busy", busy, 1'b0);
        @(negedge clk);
        #4 chk32("e_deq_count", 32'(deq_seen - d0), 32'd2);
        @(negedge clk);

        // Flush in REQ drops a load
        head_valid = 1; head_is_load = 1; head_tag = 4'd9; head_addr = 32'h500;
        @(negedge clk); flush = 1; mem_ready = 1;
        #3 chk1("g_req", mem_req, 1'b0); chk1("g_deq", deq, 1'b0);
        @(negedge clk); flush = 0; mem_ready = 0; head_valid = 0;
        #3 chk1("g_busy", busy, 1'b0);
        @(negedge clk);

        // Flush in REQ does not stop a committed store
        head_valid = 1; head_is_load = 0; head_addr = 32'h600; head_data = 32'h66; store_commit = 1;
        @(negedge clk); store_commit = 0; flush = 1; mem_ready = 1;
        #3 chk1("h_req", mem_req, 1'b1); chk1("h_deq", deq, 1'b1);
        @(negedge clk); flush = 0; mem_ready = 0; head_valid = 0;
        #3 chk1("h_busy", busy, 1'b0);
        @(negedge clk);

        // Stray rvalid on the handshake is ignored; flush in WB suppresses writeback
        head_valid = 1; head_is_load = 1; head_tag = 4'hA; head_addr = 32'h700;
        @(negedge clk); mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hBAD;
        @(negedge clk); mem_ready = 0; mem_rvalid = 0;
        #3 chk1("i_busy", busy, 1'b1); chk1("i_wbv", wb_valid, 1'b0);
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h600D;
        @(negedge clk); mem_rvalid = 0; flush = 1; head_valid = 0;
        #3 chk1("i_wb_flush_wbv", wb_valid, 1'b0); chk1("i_wb_flush_deq", deq, 1'b0);
        chk32("i_wb_data", wb_data, 32'h600D);
        @(negedge clk); flush = 0;
        #3 chk1("i_busy_after", busy, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of a REQ cycle
        chk1("j_terr_sticky", timeout_err, 1'b1);
        head_valid = 1; head_is_load = 1; head_tag = 4'hB; head_addr = 32'h800;
        @(negedge clk);
        #1 chk1("j_pre_req", mem_req, 1'b1);
        #1 rst = 1'b0;
        #1 chk1("j_req", mem_req, 1'b0); chk1("j_busy", busy, 1'b0); chk1("j_deq", deq, 1'b0);
        chk1("j_we", mem_we, 1'b0); chk1("j_wbv", wb_valid, 1'b0); chk1("j_terr", timeout_err, 1'b0);
        chk32("j_addr", mem_addr, 32'h0); chk32("j_wdata", mem_wdata, 32'h0);
        chk32("j_wb_tag", 32'(wb_tag), 32'h0); chk32("j_wb_data", wb_data, 32'h0);
        @(negedge clk); head_valid = 0;
        @(negedge clk); rst = 1'b1; mem_rvalid = 1; mem_rdata = 32'h999;
        #3 chk1("j_late_wbv", wb_valid, 1'b0); chk1("j_late_busy", busy, 1'b0);
        @(negedge clk); mem_rvalid = 0;
        #3 chk1("j_late_wbv2", wb_valid, 1'b0); chk32("j_late_wb_data", wb_data, 32'h0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
